// File: rtl/beam_pkg.sv
// Shared types and helpers for the delay-and-sum beam scanner.
package beam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ACCUM,
    S_POWER,
    S_COMPARE,
    S_FINISH
  } scan_state_t;

  // Widest real/imag component the unpack helpers can handle.
  localparam int UNPACK_W = 32;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator width: full complex product plus headroom for summing every mic.
  function automatic int acc_width(input int samp_w, input int coef_w, input int num_mics);
    return samp_w + coef_w + 1 + clog2_safe(num_mics);
  endfunction

  // Power width: sum of two squares of an accumulator value.
  function automatic int pwr_width(input int acc_w);
    return 2 * acc_w + 1;
  endfunction

  localparam int DEF_ACC_W = acc_width(14, 14, 4);
  localparam int DEF_PWR_W = pwr_width(DEF_ACC_W);

  // Real part of a {real, imag} pair of w-bit fields, sign-extended.
  function automatic logic [UNPACK_W-1:0] upper_half(input logic [2*UNPACK_W-1:0] word,
                                                     input int w);
    logic [UNPACK_W-1:0] r;
    for (int i = 0; i < UNPACK_W; i++)
      r[i] = (i < w) ? word[w + i] : word[2*w - 1];
    return r;
  endfunction

  // Imaginary part of a {real, imag} pair of w-bit fields, sign-extended.
  function automatic logic [UNPACK_W-1:0] lower_half(input logic [2*UNPACK_W-1:0] word,
                                                     input int w);
    logic [UNPACK_W-1:0] r;
    for (int i = 0; i < UNPACK_W; i++)
      r[i] = (i < w) ? word[i] : word[w - 1];
    return r;
  endfunction

endpackage

// File: rtl/beam_cmult.sv
// Combinational signed complex multiplier with full-precision outputs.
module beam_cmult #(
  parameter int SAMP_W = 14,
  parameter int COEF_W = 14
) (
  input  logic signed [SAMP_W-1:0]      s_re,
  input  logic signed [SAMP_W-1:0]      s_im,
  input  logic signed [COEF_W-1:0]      c_re,
  input  logic signed [COEF_W-1:0]      c_im,
  output logic signed [SAMP_W+COEF_W:0] p_re,
  output logic signed [SAMP_W+COEF_W:0] p_im
);

  localparam int PW = SAMP_W + COEF_W;

  logic signed [PW-1:0] s_re_x, s_im_x, c_re_x, c_im_x;
  logic signed [PW-1:0] rr, ii, ri, ir;

  // Sign-extend operands to product width, form the four partial products, then combine.
  always_comb begin
    s_re_x = {{COEF_W{s_re[SAMP_W-1]}}, s_re};
    s_im_x = {{COEF_W{s_im[SAMP_W-1]}}, s_im};
    c_re_x = {{SAMP_W{c_re[COEF_W-1]}}, c_re};
    c_im_x = {{SAMP_W{c_im[COEF_W-1]}}, c_im};
    rr = c_re_x * s_re_x;
    ii = c_im_x * s_im_x;
    ri = c_re_x * s_im_x;
    ir = c_im_x * s_re_x;
    p_re = {rr[PW-1], rr} - {ii[PW-1], ii};
    p_im = {ri[PW-1], ri} + {ir[PW-1], ir};
  end

endmodule

// File: rtl/beam_scan.sv
// Delay-and-sum beam scanner: snapshots one FFT bin per mic, steers every enabled beam
// and reports the strongest one with its power and direction of arrival.
module beam_scan
  import beam_pkg::*;
#(
  parameter int NUM_MICS  = 4,
  parameter int NUM_BEAMS = 13,
  parameter int BEAM_W    = 4,
  parameter int BIN_W     = 10,
  parameter int SAMP_W    = 14,
  parameter int COEF_W    = 14,
  parameter int DOA_MIN   = -90,
  parameter int DOA_STEP  = 15,
  parameter int DOA_W     = 8,
  localparam int MIC_W    = clog2_safe(NUM_MICS),
  localparam int CA_W     = BEAM_W + MIC_W,
  localparam int PROD_W   = SAMP_W + COEF_W + 1,
  localparam int ACC_W    = acc_width(SAMP_W, COEF_W, NUM_MICS),
  localparam int PWR_W    = pwr_width(ACC_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BIN_W-1:0]             bin,
  input  logic [NUM_BEAMS-1:0]         beam_mask,
  output logic [BIN_W-1:0]             fft_rdaddr,
  input  logic [NUM_MICS*2*SAMP_W-1:0] fft_q,
  output logic [CA_W-1:0]              coef_addr,
  input  logic [2*COEF_W-1:0]          coef_q,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid,
  output logic [BEAM_W-1:0]            best_beam,
  output logic [PWR_W-1:0]             best_power,
  output logic signed [DOA_W-1:0]      doa
);

  scan_state_t state_q, state_d;

  logic [NUM_BEAMS-1:0]     mask_q;
  logic [BEAM_W-1:0]        beam_q, next_beam;
  logic [MIC_W-1:0]         mic_q;
  logic                     load_phase;
  logic                     first_q;
  logic                     scanned;
  logic signed [SAMP_W-1:0] snap_re [NUM_MICS];
  logic signed [SAMP_W-1:0] snap_im [NUM_MICS];
  logic signed [COEF_W-1:0] coef_re, coef_im;
  logic signed [PROD_W-1:0] prod_re, prod_im;
  logic signed [ACC_W-1:0]  re_acc, im_acc;
  logic signed [PWR_W-1:0]  re_wide, im_wide;
  logic [PWR_W-1:0]         power_q, max_pwr;
  logic [BEAM_W-1:0]        max_beam;
  int                       doa_full;

  localparam logic [BEAM_W-1:0] LAST_BEAM = BEAM_W'(NUM_BEAMS - 1);
  localparam logic [MIC_W-1:0]  LAST_MIC  = MIC_W'(NUM_MICS - 1);

  function automatic logic [CA_W-1:0] caddr(input logic [BEAM_W-1:0] b, input int m);
    return CA_W'(int'(b) * NUM_MICS + m);
  endfunction

  assign next_beam = beam_q + BEAM_W'(1);

  beam_cmult #(
    .SAMP_W (SAMP_W),
    .COEF_W (COEF_W)
  ) u_cmult (
    .s_re (snap_re[mic_q]),
    .s_im (snap_im[mic_q]),
    .c_re (coef_re),
    .c_im (coef_im),
    .p_re (prod_re),
    .p_im (prod_im)
  );

  // Split the ROM word and widen the accumulators ahead of squaring.
  always_comb begin
    coef_re = COEF_W'(upper_half((2*UNPACK_W)'(coef_q), COEF_W));
    coef_im = COEF_W'(lower_half((2*UNPACK_W)'(coef_q), COEF_W));
    re_wide = {{(PWR_W-ACC_W){re_acc[ACC_W-1]}}, re_acc};
    im_wide = {{(PWR_W-ACC_W){im_acc[ACC_W-1]}}, im_acc};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: disabled beams skip straight to a single COMPARE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    if (load_phase) state_d = mask_q[0] ? S_FETCH : S_COMPARE;
      S_FETCH:   state_d = S_ACCUM;
      S_ACCUM:   if (mic_q == LAST_MIC) state_d = S_POWER;
      S_POWER:   state_d = S_COMPARE;
      S_COMPARE: begin
        if (beam_q == LAST_BEAM) state_d = S_FINISH;
        else                     state_d = mask_q[next_beam] ? S_FETCH : S_COMPARE;
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: snapshot, accumulate, square, track the maximum and publish results.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q       <= '0;
      beam_q       <= '0;
      mic_q        <= '0;
      load_phase   <= 1'b0;
      first_q      <= 1'b0;
      scanned      <= 1'b0;
      re_acc       <= '0;
      im_acc       <= '0;
      power_q      <= '0;
      max_pwr      <= '0;
      max_beam     <= '0;
      fft_rdaddr   <= '0;
      coef_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      best_beam    <= '0;
      best_power   <= '0;
      for (int m = 0; m < NUM_MICS; m++) begin
        snap_re[m] <= '0;
        snap_im[m] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            fft_rdaddr <= bin;
            mask_q     <= beam_mask;
            beam_q     <= '0;
            max_pwr    <= '0;
            max_beam   <= '0;
            first_q    <= 1'b1;
            load_phase <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          load_phase <= 1'b1;
          if (load_phase) begin
            for (int m = 0; m < NUM_MICS; m++) begin
              snap_re[m] <= SAMP_W'(upper_half((2*UNPACK_W)'(fft_q[m*2*SAMP_W +: 2*SAMP_W]), SAMP_W));
              snap_im[m] <= SAMP_W'(lower_half((2*UNPACK_W)'(fft_q[m*2*SAMP_W +: 2*SAMP_W]), SAMP_W));
            end
            coef_addr <= caddr('0, 0);
          end
        end
        S_FETCH: begin
          re_acc    <= '0;
          im_acc    <= '0;
          mic_q     <= '0;
          coef_addr <= caddr(beam_q, 1);
        end
        S_ACCUM: begin
          re_acc <= re_acc + {{(ACC_W-PROD_W){prod_re[PROD_W-1]}}, prod_re};
          im_acc <= im_acc + {{(ACC_W-PROD_W){prod_im[PROD_W-1]}}, prod_im};
          mic_q  <= mic_q + MIC_W'(1);
          if (int'(mic_q) + 2 < NUM_MICS)
            coef_addr <= caddr(beam_q, int'(mic_q) + 2);
        end
        S_POWER: begin
          power_q <= re_wide * re_wide + im_wide * im_wide;
        end
        S_COMPARE: begin
          if (mask_q[beam_q] && (first_q || power_q > max_pwr)) begin
            max_pwr  <= power_q;
            max_beam <= beam_q;
            first_q  <= 1'b0;
          end
          if (beam_q != LAST_BEAM) begin
            beam_q    <= next_beam;
            coef_addr <= caddr(next_beam, 0);
          end
        end
        S_FINISH: begin
          best_beam    <= max_beam;
          best_power   <= max_pwr;
          result_valid <= |mask_q;
          scanned      <= 1'b1;
          done         <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Direction of arrival of the best beam; held at zero until a scan has completed since reset.
  always_comb begin
    doa_full = DOA_MIN + DOA_STEP * int'(best_beam);
    doa      = scanned ? doa_full[DOA_W-1:0] : '0;
  end

endmodule

// File: tb/tb_beam_scan.sv
// Self-checking bench for beam_scan with behavioural FFT RAM and delay ROM models.
module tb_beam_scan;

  localparam int    LIMIT   = 2000;
  localparam logic [9:0] RAM_BIN = 10'd37;

  logic         clk;
  logic         reset;
  logic         start;
  logic [9:0]   bin;
  logic [12:0]  beam_mask;
  logic [9:0]   fft_rdaddr;
  logic [111:0] fft_q;
  logic [5:0]   coef_addr;
  logic [27:0]  coef_q;
  logic         busy;
  logic         done;
  logic         result_valid;
  logic [3:0]   best_beam;
  logic [62:0]  best_power;
  logic signed [7:0] doa;

  logic signed [13:0] mic_re [4];
  logic signed [13:0] mic_im [4];
  logic [111:0] ram_word;
  logic [27:0]  rom [64];

  int tests;
  int failures;

  typedef struct {
    int          cfg;
    logic [12:0] mask;
    int          cycles;
    int          beam;
    longint      power;
    int          doa;
    int          valid;
  } vec_t;

  vec_t vecs [8];

  beam_scan dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bin          (bin),
    .beam_mask    (beam_mask),
    .fft_rdaddr   (fft_rdaddr),
    .fft_q        (fft_q),
    .coef_addr    (coef_addr),
    .coef_q       (coef_q),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .best_beam    (best_beam),
    .best_power   (best_power),
    .doa          (doa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-mic bin values the way the FFT RAMs present them.
  always_comb begin
    ram_word = '0;
    for (int m = 0; m < 4; m++) ram_word[m*28 +: 28] = {mic_re[m], mic_im[m]};
  end

  // FFT RAMs and delay ROM, both with one cycle of read latency.
  always @(posedge clk) begin
    fft_q  <= (fft_rdaddr == RAM_BIN) ? ram_word : '0;
    coef_q <= rom[coef_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setCoef(input int b, input int m, input int cr, input int ci);
    logic [13:0] r;
    logic [13:0] i;
    r = 14'(cr);
    i = 14'(ci);
    rom[b*4 + m] = {r, i};
  endtask

  task automatic setMic(input int m, input int re, input int im);
    mic_re[m] = 14'(re);
    mic_im[m] = 14'(im);
  endtask

  task automatic loadConfig(input int c);
    for (int a = 0; a < 64; a++) rom[a] = '0;
    for (int m = 0; m < 4; m++) setMic(m, 100, 0);
    case (c)
      0: for (int m = 0; m < 4; m++) setCoef(5, m, 1, 0);
      1: begin
        for (int m = 0; m < 4; m++) begin
          setCoef(3, m, 1, 0);
          setCoef(7, m, 1, 0);
        end
        setCoef(1, 0, 0, 1);
      end
      2: begin
        setMic(0, 3, -4);
        setMic(1, -2, 1);
        setMic(2, 0, 5);
        setMic(3, 7, 0);
        setCoef(10, 0, 2, -1);
        setCoef(10, 1, 1, 0);
        setCoef(10, 2, 0, 1);
        setCoef(10, 3, -1, 0);
        for (int m = 0; m < 4; m++) setCoef(2, m, 1, 0);
      end
      default: ;
    endcase
  endtask

  // Issue one start in IDLE and count edges until done, bounded by LIMIT.
  task automatic applyStimulus(input logic [12:0] mask, output int cycles);
    beam_mask = mask;
    bin       = RAM_BIN;
    start     = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!done && cycles < LIMIT);
  endtask

  task automatic checkResults(input string tag, input int beam, input longint power,
                              input int exp_doa, input int valid);
    checkOutput({tag, " best_beam"}, longint'(best_beam), beam);
    checkOutput({tag, " best_power"}, longint'(best_power), power);
    checkOutput({tag, " doa"}, longint'(doa), exp_doa);
    checkOutput({tag, " result_valid"}, longint'(result_valid), valid);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, longint'(busy), 0);
    checkOutput({tag, " done"}, longint'(done), 0);
    checkOutput({tag, " fft_rdaddr"}, longint'(fft_rdaddr), 0);
    checkOutput({tag, " coef_addr"}, longint'(coef_addr), 0);
    checkResults(tag, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int done_count;
    int n;

    tests     = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    bin       = '0;
    beam_mask = '0;
    loadConfig(3);

    vecs[0] = '{cfg: 0, mask: 13'h1FFF, cycles: 94, beam: 5,  power: 160000, doa: -15, valid: 1};
    vecs[1] = '{cfg: 1, mask: 13'h1FFF, cycles: 94, beam: 3,  power: 160000, doa: -45, valid: 1};
    vecs[2] = '{cfg: 2, mask: 13'h1FFF, cycles: 94, beam: 10, power: 244,    doa: 60,  valid: 1};
    vecs[3] = '{cfg: 2, mask: 13'h0024, cycles: 28, beam: 2,  power: 68,     doa: -60, valid: 1};
    vecs[4] = '{cfg: 3, mask: 13'h0001, cycles: 22, beam: 0,  power: 0,     doa: -90, valid: 1};
    vecs[5] = '{cfg: 3, mask: 13'h0010, cycles: 22, beam: 4,  power: 0,     doa: -30, valid: 1};
    vecs[6] = '{cfg: 3, mask: 13'h0000, cycles: 16, beam: 0,  power: 0,     doa: -90, valid: 0};
    vecs[7] = '{cfg: 1, mask: 13'h1FF7, cycles: 88, beam: 7,  power: 160000, doa: 15,  valid: 1};

    repeat (3) step();
    checkResetState("reset");
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      loadConfig(vecs[v].cfg);
      applyStimulus(vecs[v].mask, cycles);
      checkOutput({tag, " latency"}, cycles, vecs[v].cycles);
      checkResults(tag, vecs[v].beam, vecs[v].power, vecs[v].doa, vecs[v].valid);
      checkOutput({tag, " busy at done"}, longint'(busy), 0);
      step();
      checkOutput({tag, " done width"}, longint'(done), 0);
    end

    // Start pulses while busy and RAM changes after the snapshot must not disturb the scan.
    loadConfig(2);
    beam_mask  = 13'h1FFF;
    bin        = RAM_BIN;
    start      = 1'b1;
    step();
    start      = 1'b0;
    done_count = 0;
    cycles     = 0;
    for (n = 1; n <= 110; n++) begin
      step();
      if (done) begin
        done_count++;
        if (done_count == 1) begin
          cycles = n;
          checkResults("perturb", 10, 244, 60, 1);
        end
      end
      if (n == 5) for (int m = 0; m < 4; m++) setMic(m, 50, 50);
      start = (n >= 10 && n <= 20);
    end
    checkOutput("perturb latency", cycles, 94);
    checkOutput("perturb done count", done_count, 1);

    // Reset in the middle of a scan aborts it with no done pulse.
    loadConfig(0);
    beam_mask = 13'h1FFF;
    bin       = RAM_BIN;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (n = 1; n <= 40; n++) step();
    checkOutput("midscan busy", longint'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkResetState("midreset");
    done_count = 0;
    for (n = 0; n < 150; n++) begin
      step();
      if (done) done_count++;
    end
    checkOutput("midreset done count", done_count, 0);

    applyStimulus(13'h1FFF, cycles);
    checkOutput("restart latency", cycles, 94);
    checkResults("restart", 5, 160000, -15, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/beam_scan.md
Name: beam_scan

Overview:
- Parametrised delay-and-sum beam scanner for the acoustic DOA pipeline; sits after the frequency detector and FFT RAMs.
- On start, snapshots one FFT bin from every microphone channel.
- For each enabled steering beam: multiplies each channel by its ROM delay coefficient, sums the products and computes output power.
- Reports the strongest beam, its power and its DOA.
- Generalises the fixed 4-mic/13-beam scanner with parametric channel/beam counts, a beam-enable mask, a start/busy/done handshake, and an explicit result-valid flag.

Parameters:
- NUM_MICS, 4, microphone channels (≥2)
- NUM_BEAMS, 13, steering beams (≥1, ≤2^BEAM_W)
- BEAM_W, 4, width of beam index
- BIN_W, 10, FFT bin address width
- SAMP_W, 14, width of each real/imag FFT component (signed)
- COEF_W, 14, width of each real/imag delay coefficient (signed)
- DOA_MIN, -90, angle of beam 0 in degrees
- DOA_STEP, 15, degrees between adjacent beams
- DOA_W, 8, signed DOA output width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request a scan; sampled only in IDLE
- bin  in  BIN_W  FFT bin to scan; latched when start is accepted
- beam_mask  in  NUM_BEAMS  bit b=1 enables beam b; latched when start is accepted
- fft_rdaddr  out  BIN_W  common read address for all FFT RAMs
- fft_q  in  NUM_MICS*2*SAMP_W  packed RAM data; mic m at slice m; within a slice, real in upper half, imag in lower; RAM latency 1 cycle
- coef_addr  out  BEAM_W+clog2(NUM_MICS)  delay ROM address = beam*NUM_MICS + mic
- coef_q  in  2*COEF_W  ROM data, real in upper half, imag in lower; latency 1 cycle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results update
- result_valid  out  1  1 if at least one beam was enabled in the last scan
- best_beam  out  BEAM_W  index of max-power beam
- best_power  out  PWR_W  power of best beam, where ACC_W = SAMP_W+COEF_W+1+clog2(NUM_MICS) and PWR_W = 2*ACC_W+1
- doa  out  DOA_W  signed: DOA_MIN + DOA_STEP*best_beam

Behaviour:
- Reset: state=IDLE; busy, done, result_valid, best_beam, best_power, doa all 0; fft_rdaddr=0; coef_addr=0. Reset mid-scan aborts immediately; no done pulse follows.
- One clock, all state updated on posedge clk; reset has priority over everything.
- States: IDLE, LOAD, FETCH, ACCUM, POWER, COMPARE, FINISH.
- IDLE: on start=1, latch bin and beam_mask; drive fft_rdaddr=bin; beam=0; clear max; set busy; go to LOAD. start while busy is ignored (no queueing).
- LOAD (2 cycles): cycle 1 waits for RAM latency; cycle 2 captures fft_q into per-mic snapshot registers. Later RAM changes do not affect the scan.
- Disabled beam (mask bit 0): consumes exactly 1 cycle in COMPARE with no update, then advances.
- Enabled beam, FETCH/ACCUM: coef_addr issued for mic 0 in FETCH. In each ACCUM cycle, the coefficient for mic m is multiplied and accumulated while the address for mic m+1 is issued. NUM_MICS ACCUM cycles. Accumulators are cleared at beam start.
- Complex product is full precision: re = cr*sr - ci*si, im = cr*si + ci*sr. Sign-extend to ACC_W before summing; no overflow possible by width choice.
- POWER (1 cycle): register re_acc^2 + im_acc^2 (unsigned, PWR_W).
- COMPARE (1 cycle): update if power > max, strictly. Ties keep the lower beam index. The first enabled beam always loads max, even with power 0.
- Per enabled beam cost: NUM_MICS+3 cycles. Per disabled beam cost: 1 cycle.
- After the last beam, go to FINISH. In FINISH: latch best_beam, best_power, doa and result_valid (= |beam_mask); pulse done; drop busy; return to IDLE.
- start may be accepted the cycle after done.
- Outputs hold their values until the next done or reset.
- All-masked scan: result_valid=0, best_beam=0, best_power=0, doa=DOA_MIN.
- Latency from the start-accept edge to done: 2 + Σ(cost per beam) + 1 cycles.
  - All beams enabled, defaults: 2 + 13*7 + 1 = 94 cycles.
- doa is computed combinationally from the registered best_beam, truncated to DOA_W.

Decomposition:
- Package beam_pkg holds:
  - state enum type
  - function clog2_safe
  - localparam formulas for ACC_W and PWR_W
  - helper to unpack the fft_q and coef_q slices
- One sub-module, beam_cmult: a combinational signed complex multiplier parametrised by SAMP_W and COEF_W, with full-precision outputs.
- The beam_scan FSM, snapshot registers, accumulators, squarer and max tracker stay in the top module.

Test Plan:
- Defaults; ROM coefficient (1,0) only for beam 5 (all others 0); all mics = (100,0); mask all 1s.
  - Expect done exactly 94 cycles after start, best_beam=5, best_power=160000, doa=-15, result_valid=1.
- Beams 3 and 7 produce equal power, others lower → best_beam=3 (tie keeps lower index).
- Mask = 0x0001 (only beam 0 enabled), all powers 0.
  - Expect best_beam=0, best_power=0, result_valid=1.
  - Expect done at cycle 2 + 7 + 12 + 1 = 22.
- Mask = 0.
  - Expect done at cycle 2 + 13 + 1 = 16, result_valid=0, doa=-90.
- Assert start during busy, and change fft_q after LOAD.
  - Expect results identical to an unperturbed run and a single done pulse.
- Assert reset at cycle 40 of a scan.
  - Expect busy=0 and all outputs 0 on the next cycle, no done pulse.
  - A new start then completes normally.
